// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle shift-add multiplier.
// Captures the winning operand pair, launches the multiplier, and returns a tagged product.
module mult_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned TMO = N + 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           req0_ready,
  output logic           req1_ready,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [2*N-1:0] rsp_p,
  output logic           err,
  output logic           mul_load,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic           mul_valid,
  input  logic [2*N-1:0] mul_p
);

  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StWait} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mul_load_q, mul_load_d;
  logic [N-1:0]     mul_a_q, mul_a_d;
  logic [N-1:0]     mul_b_q, mul_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [2*N-1:0]   rsp_p_q, rsp_p_d;
  logic             err_q, err_d;
  logic             grant1, xfer;

  // req1 wins when alone, or on contention when req0 was granted last.
  always_comb begin
    grant1 = req1_valid && (!req0_valid || !last_grant_q);
    xfer   = (state_q == StIdle) && (req0_valid || req1_valid);
  end

  assign req0_ready = xfer && !grant1;
  assign req1_ready = xfer && grant1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    mul_load_d   = 1'b0;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_p_d      = rsp_p_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          state_d      = StLoad;
          mul_load_d   = 1'b1;
          mul_a_d      = grant1 ? req1_a : req0_a;
          mul_b_d      = grant1 ? req1_b : req0_b;
          id_d         = grant1;
          last_grant_d = grant1;
        end
      end
      StLoad: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        // mul_valid is only trusted here, one cycle after the load strobe.
        if (mul_valid) begin
          rsp_p_d     = mul_p;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = StIdle;
        end else if (cnt_q == CW'(TMO - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      mul_load_q   <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_p_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      mul_load_q   <= mul_load_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_p_q      <= rsp_p_d;
      err_q        <= err_d;
    end
  end

  assign mul_load  = mul_load_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: vector table, corner-case sequences and a randomized
// run checked against a transaction-level timing model with an N-cycle multiplier.
module tb_mult_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req1_valid;
  logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           req0_ready, req1_ready;
  logic           rsp_valid, rsp_id, err, mul_load, mul_valid;
  logic [2*N-1:0] rsp_p, mul_p;
  logic [N-1:0]   mul_a, mul_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req0_ready(req0_ready),
    .req1_ready(req1_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .err       (err),
    .mul_load  (mul_load),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_valid (mul_valid),
    .mul_p     (mul_p)
  );

  // Multiplier: busy for N cycles after a load; not reset by rst_n.
  logic [2*N-1:0] mprod = '0;
  int             mbusy = 0;
  logic           stall = 1'b0;
  always @(posedge clk) begin
    if (mul_load) begin
      mprod <= {{N{1'b0}}, mul_a} * {{N{1'b0}}, mul_b};
      mbusy <= N;
    end else if (mbusy > 0) begin
      mbusy <= mbusy - 1;
    end
  end
  assign mul_valid = !stall && (mbusy == 0);
  assign mul_p     = mprod;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  logic prev_load = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("one_ready", req0_ready && req1_ready, 0);
      chk("load_width", prev_load && mul_load, 0);
      prev_load = mul_load;
    end else begin
      prev_load = 1'b0;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One isolated transaction: grant, load, response latency, id, product, hold.
  task automatic do_txn(input logic v0, input int a0, input int b0, input logic v1,
                        input int a1, input int b1, input logic eid, input int ep,
                        input string nm);
    int k;
    @(posedge clk); #1;
    req0_valid = v0; req0_a = N'(a0); req0_b = N'(b0);
    req1_valid = v1; req1_a = N'(a1); req1_b = N'(b1);
    @(negedge clk);
    chk({nm, "_rdy0"}, req0_ready, eid == 1'b0);
    chk({nm, "_rdy1"}, req1_ready, eid == 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_load"}, mul_load, 1);
    chk({nm, "_mula"}, mul_a, eid ? a1 : a0);
    chk({nm, "_mulb"}, mul_b, eid ? b1 : b0);
    k = 2;
    @(negedge clk);
    while (!rsp_valid && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk({nm, "_lat"}, k, N + 3);
    chk({nm, "_id"}, rsp_id, eid);
    chk({nm, "_p"}, rsp_p, ep);
    @(negedge clk);
    chk({nm, "_pulse"}, rsp_valid, 0);
    chk({nm, "_hold"}, rsp_p, ep);
  endtask

  typedef struct {
    logic v0; int a0; int b0;
    logic v1; int a1; int b1;
    logic eid; int ep;
  } vec_t;

  typedef struct {
    int   due;
    logic id;
    int   p;
  } rsp_t;

  vec_t tbl[8];
  rsp_t q[$];

  initial begin : main
    int   k, seen, free_at, load_at, ld_a, ld_b, last_p;
    logic rlast;

    tbl[0] = '{1'b1, 15, 15, 1'b1, 7, 9, 1'b0, 225};
    tbl[1] = '{1'b1, 15, 15, 1'b1, 7, 9, 1'b1, 63};
    tbl[2] = '{1'b1, 15, 15, 1'b1, 7, 9, 1'b0, 225};
    tbl[3] = '{1'b1, 15, 15, 1'b1, 7, 9, 1'b1, 63};
    tbl[4] = '{1'b1, 3, 5, 1'b0, 0, 0, 1'b0, 15};
    tbl[5] = '{1'b0, 0, 0, 1'b1, 2, 3, 1'b1, 6};
    tbl[6] = '{1'b1, 1, 1, 1'b1, 0, 9, 1'b0, 1};
    tbl[7] = '{1'b1, 12, 13, 1'b1, 5, 5, 1'b1, 25};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_p", rsp_p, 0);
    chk("rst_err", err, 0);
    chk("rst_load", mul_load, 0);
    chk("rst_mula", mul_a, 0);
    chk("rst_rdy", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (tbl[i])
      do_txn(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1,
             tbl[i].eid, tbl[i].ep, $sformatf("vec%0d", i));

    // req1 back-to-back: second transfer lands in the first rsp_valid cycle.
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd6;
    @(negedge clk);
    chk("b2b_rdy_first", req1_ready, 1);
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 1) req1_a = 4'd9;
      if (c == 8) req1_valid = 1'b0;
      @(negedge clk);
      chk("b2b_rdy", req1_ready, c == 7);
      chk("b2b_rsp", rsp_valid, (c == 7) || (c == 14));
      if (c == 7) chk("b2b_p1", rsp_p, 30);
      if (c == 14) begin
        chk("b2b_p2", rsp_p, 54);
        chk("b2b_id", rsp_id, 1);
      end
    end

    // Stalled multiplier: timeout after TMO wait cycles, then accept again.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3; stall = 1'b1;
    @(negedge clk);
    chk("to_rdy", req0_ready, 1);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) req0_valid = 1'b0;
      if (c == 10) begin
        req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd4; stall = 1'b0;
      end
      @(negedge clk);
      chk("to_norsp", rsp_valid, 0);
      chk("to_err", err, c == 10);
    end
    chk("to_accept", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    k = 11;
    @(negedge clk);
    while (!rsp_valid && k < 30) begin
      k++;
      @(negedge clk);
    end
    chk("to_next_lat", k, 17);
    chk("to_next_p", rsp_p, 16);
    chk("to_sticky", err, 1);

    // Reset two cycles after the load strobe abandons the operation.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd7;
    @(negedge clk);
    chk("ar_rdy", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("ar_load", mul_load, 1);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0; req0_valid = 1'b1;
    #1;
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_rsp_id", rsp_id, 0);
    chk("ar_rsp_p", rsp_p, 0);
    chk("ar_err", err, 0);
    chk("ar_load0", mul_load, 0);
    chk("ar_mul", {mul_a, mul_b}, 0);
    chk("ar_rdy0", req0_ready, 1);
    chk("ar_rdy1", req1_ready, 0);
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("ar_no_rsp", seen, 0);
    do_txn(1'b1, 6, 7, 1'b1, 2, 2, 1'b0, 42, "post_rst");

    // Randomized traffic against a cycle-arithmetic transaction model.
    do_reset();
    free_at = 0; load_at = -1; rlast = 1'b1; last_p = 0; ld_a = 0; ld_b = 0;
    q.delete();
    for (int i = 0; i < 420; i++) begin
      logic v0, v1, win, erv;
      int   a0, b0, a1, b1;
      v0 = 1'b0; v1 = 1'b0;
      a0 = $urandom_range(0, 15); b0 = $urandom_range(0, 15);
      a1 = $urandom_range(0, 15); b1 = $urandom_range(0, 15);
      if (i < 400) begin
        v0 = ($urandom_range(0, 3) != 0);
        v1 = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      req0_valid = v0; req0_a = N'(a0); req0_b = N'(b0);
      req1_valid = v1; req1_a = N'(a1); req1_b = N'(b1);
      @(negedge clk);
      win = (v0 && v1) ? !rlast : v1;
      chk("rnd_rdy0", req0_ready, (i >= free_at) && (v0 || v1) && !win);
      chk("rnd_rdy1", req1_ready, (i >= free_at) && (v0 || v1) && win);
      chk("rnd_load", mul_load, i == load_at);
      if (i == load_at) chk("rnd_mul", {mul_a, mul_b}, {N'(ld_a), N'(ld_b)});
      erv = (q.size() > 0) && (q[0].due == i);
      chk("rnd_rsp_valid", rsp_valid, erv);
      if (erv) begin
        chk("rnd_id", rsp_id, q[0].id);
        chk("rnd_p", rsp_p, q[0].p);
        last_p = q[0].p;
        void'(q.pop_front());
      end else begin
        chk("rnd_hold", rsp_p, last_p);
      end
      chk("rnd_err", err, 0);
      if ((i >= free_at) && (v0 || v1)) begin
        rlast   = win;
        free_at = i + N + 3;
        load_at = i + 1;
        ld_a    = win ? a1 : a0;
        ld_b    = win ? b1 : b0;
        q.push_back('{i + N + 3, win, ld_a * ld_b});
      end
    end
    chk("rnd_drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: N, default 4, operand width of the shared shift-add multiplier; N >= 2.
REQ-002 Parameter: TMO, default N+4, max cycles spent in WAIT before timeout.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester i presents an operand pair.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  N  operands of requester i.
REQ-007 req0_ready / req1_ready  output  1  requester i accepted this cycle (valid && ready = transfer).
REQ-008 rsp_valid  output  1  one-cycle pulse, result available.
REQ-009 rsp_id  output  1  requester owning the result.
REQ-010 rsp_p  output  2N  product; held until next rsp_valid.
REQ-011 err  output  1  sticky timeout flag.
REQ-012 mul_load  output  1  one-cycle load strobe to multiplier.
REQ-013 mul_a, mul_b  output  N  registered operands to multiplier.
REQ-014 mul_valid  input  1  multiplier idle/result ready (low while running).
REQ-015 mul_p  input  2N  multiplier product.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, WAIT; encoding free.
REQ-017 IDLE: if any req valid, winner's ready SHALL be high combinationally, operands and id registered, next state LOAD; else stay IDLE.
REQ-018 At most one reqX_ready high per cycle; both ready low outside IDLE.
REQ-019 Arbitration: single requester wins; if both valid, the one not granted last wins (round-robin); last_grant updated on every transfer.
REQ-020 LOAD: mul_load=1 for exactly one cycle with mul_a/mul_b = captured operands; next state WAIT, wait counter cleared.
REQ-021 WAIT: mul_valid sampled only from the cycle after LOAD (stale-high valid before load SHALL be ignored).
REQ-022 WAIT with mul_valid=1: rsp_p <= mul_p, rsp_id <= captured id, rsp_valid pulses next cycle; next state IDLE.
REQ-023 WAIT with mul_valid=0: counter increments; when counter reaches TMO-1, err <= 1, no rsp_valid, next state IDLE.
REQ-024 Latency: transfer at cycle t -> mul_load at t+1 -> rsp_valid at t+N+3 (t+7 for N=4), given multiplier running N cycles.
REQ-025 IDLE is entered in the rsp_valid cycle; a new transfer MAY occur in that same cycle (throughput one product per N+3 cycles).
REQ-026 mul_load SHALL be low in all states except LOAD.
REQ-027 rsp_p is plain 2N-bit product; no overflow possible for unsigned N x N.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, reqX_ready per IDLE rule, rsp_valid=0, rsp_id=0, rsp_p=0, err=0, mul_load=0, mul_a=mul_b=0, last_grant=1 (req0 wins first contention), counter=0.
REQ-029 Reset mid-LOAD/WAIT SHALL abandon the operation with no rsp_valid; multiplier state is not reset, next mul_load overrides it.
REQ-030 err SHALL clear only on reset.

Verification (N=4)
REQ-031 req0 only, a=3 b=5 at cycle t -> req0_ready at t, mul_load at t+1, rsp_valid at t+7, rsp_id=0, rsp_p=15.
REQ-032 After reset both valid, req0=15x15, req1=7x9 held -> req0 granted first, rsp_p=225 id0; then req1, rsp_p=63 id1; alternation continues while both valid.
REQ-033 req1 only, two back-to-back transfers -> both granted to req1, second transfer in first rsp_valid cycle.
REQ-034 mul_valid tied 0 after load -> err=1 after 8 WAIT cycles, no rsp_valid, FSM back in IDLE and accepting.
REQ-035 rst_n asserted 2 cycles after mul_load -> all outputs to reset values that cycle, no rsp_valid; next request completes normally.
REQ-036 Checkers throughout: never both readys high, mul_load width exactly 1 cycle, rsp_p equals a*b of the matching transfer.
